core_pipe_ctrl: RTL and testbench

//  Pipeline sequencing controller for the IF -> IF/ID -> ID -> EX datapath.

---
 rtl/core_pipe_ctrl.sv | 171 +++++++++++++++++
 tb/tb_core_pipe_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_ctrl.sv
// Pipeline sequencing controller: load-use stalls, bus-wait holds and jump flushes for IF/ID/EX.
// Optional performance counters are built when CORE_PIPE_PERF_EN is defined.
module core_pipe_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs1,
    input  logic [4:0]        id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    input  logic              ex_is_load,
    input  logic              ex_jump_req,
    input  logic [31:0]       ex_jump_addr,
    input  logic              bus_hold_req,
    output logic              pc_hold,
    output logic              if_id_hold,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              jump_flag,
    output logic [31:0]       jump_addr_out,
    output logic [PERF_W-1:0] stall_cnt,
    output logic [PERF_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_FLUSH    = 2'd2,
        ST_HOLD     = 2'd3
    } state_t;

    // The jump cycle itself is the first flush cycle, so FLUSH needs FLUSH_CYCLES-1 more.
    localparam bit         MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [3:0] FCNT_INIT   = MULTI_FLUSH ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_fcnt;
    logic [3:0] w_fcnt_nxt;
    logic       w_hz;

    logic       w_pc_hold;
    logic       w_if_id_hold;
    logic       w_if_id_flush;
    logic       w_id_ex_flush;
    logic       w_jump_flag;

    assign w_hz = ex_is_load & ex_reg_we & (ex_rd != 5'd0) &
                  ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            ST_RUN: begin
                if (ex_jump_req) begin
                    if (MULTI_FLUSH) begin
                        w_state_nxt = ST_FLUSH;
                        w_fcnt_nxt  = FCNT_INIT;
                    end
                end else if (bus_hold_req) begin
                    w_state_nxt = ST_HOLD;
                end else if (w_hz) begin
                    w_state_nxt = ST_LU_STALL;
                end
            end
            ST_LU_STALL: w_state_nxt = ST_RUN;
            ST_FLUSH: begin
                if (r_fcnt == 4'd0) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_fcnt_nxt = r_fcnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (!bus_hold_req) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_fcnt_nxt  = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_pc_hold     = 1'b0;
        w_if_id_hold  = 1'b0;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_jump_flag   = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (ex_jump_req) begin
                    w_jump_flag   = 1'b1;
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = 1'b1;
                end else if (bus_hold_req || w_hz) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            ST_FLUSH: begin
                w_if_id_flush = 1'b1;
                w_id_ex_flush = 1'b1;
            end
            ST_HOLD: begin
                if (bus_hold_req) begin
                    w_pc_hold     = 1'b1;
                    w_if_id_hold  = 1'b1;
                    w_id_ex_flush = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Reset forces every strobe low immediately, independent of the clock.
    assign pc_hold       = w_pc_hold     & ~rst;
    assign if_id_hold    = w_if_id_hold  & ~rst;
    assign if_id_flush   = w_if_id_flush & ~rst;
    assign id_ex_flush   = w_id_ex_flush & ~rst;
    assign jump_flag     = w_jump_flag   & ~rst;
    assign jump_addr_out = jump_flag ? ex_jump_addr : 32'd0;

`ifdef CORE_PIPE_PERF_EN
    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] val);
        return (&val) ? val : val + 1'b1;
    endfunction

    logic [PERF_W-1:0] r_stall_cnt;
    logic [PERF_W-1:0] r_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (pc_hold) begin
                r_stall_cnt <= sat_inc(r_stall_cnt);
            end
            if (jump_flag) begin
                r_flush_cnt <= sat_inc(r_flush_cnt);
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Directed bench for core_pipe_ctrl: one instance with FLUSH_CYCLES=2, one with FLUSH_CYCLES=3.
module tb_core_pipe_ctrl;

`ifdef CORE_PIPE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_rs1_used, id_rs2_used, ex_reg_we, ex_is_load, ex_jump_req, bus_hold_req;
    logic [31:0] ex_jump_addr;

    logic        pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a, jump_flag_a;
    logic [31:0] jump_addr_a, stall_cnt_a, flush_cnt_a;
    logic        pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b, jump_flag_b;
    logic [31:0] jump_addr_b, stall_cnt_b, flush_cnt_b;

    logic [4:0]  s_a, s_b;
    assign s_a = {pc_hold_a, if_id_hold_a, if_id_flush_a, id_ex_flush_a, jump_flag_a};
    assign s_b = {pc_hold_b, if_id_hold_b, if_id_flush_b, id_ex_flush_b, jump_flag_b};

    // Strobe encodings {pc_hold, if_id_hold, if_id_flush, id_ex_flush, jump_flag}
    localparam logic [4:0] S_IDLE  = 5'b00000;
    localparam logic [4:0] S_STALL = 5'b11010;
    localparam logic [4:0] S_JUMP  = 5'b00111;
    localparam logic [4:0] S_FLUSH = 5'b00110;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    core_pipe_ctrl #(.FLUSH_CYCLES(2), .PERF_W(32)) u_dut_a (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr), .bus_hold_req(bus_hold_req),
        .pc_hold(pc_hold_a), .if_id_hold(if_id_hold_a), .if_id_flush(if_id_flush_a),
        .id_ex_flush(id_ex_flush_a), .jump_flag(jump_flag_a), .jump_addr_out(jump_addr_a),
        .stall_cnt(stall_cnt_a), .flush_cnt(flush_cnt_a)
    );

    core_pipe_ctrl #(.FLUSH_CYCLES(3), .PERF_W(32)) u_dut_b (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_reg_we(ex_reg_we), .ex_is_load(ex_is_load),
        .ex_jump_req(ex_jump_req), .ex_jump_addr(ex_jump_addr), .bus_hold_req(bus_hold_req),
        .pc_hold(pc_hold_b), .if_id_hold(if_id_hold_b), .if_id_flush(if_id_flush_b),
        .id_ex_flush(id_ex_flush_b), .jump_flag(jump_flag_b), .jump_addr_out(jump_addr_b),
        .stall_cnt(stall_cnt_b), .flush_cnt(flush_cnt_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr_in();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = 5'd0; ex_reg_we = 1'b0; ex_is_load = 1'b0;
        ex_jump_req = 1'b0; ex_jump_addr = 32'd0; bus_hold_req = 1'b0;
    endtask

    task automatic set_hz(input logic [4:0] rd, input logic rs1_used);
        ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd = rd;
        id_rs1 = 5'd5; id_rs1_used = rs1_used;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string tag, input logic [4:0] exp_s, input logic [31:0] exp_addr);
        check_eq({tag, "_strb"}, {27'd0, s_a}, {27'd0, exp_s});
        check_eq({tag, "_addr"}, jump_addr_a, exp_addr);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        check_eq("rst_strb_a", {27'd0, s_a}, 32'd0);
        check_eq("rst_strb_b", {27'd0, s_b}, 32'd0);
        tick();
        check_eq("rst_stall_cnt", stall_cnt_a, 32'd0);
        check_eq("rst_flush_cnt", flush_cnt_a, 32'd0);
        rst = 1'b0;
        clr_in();
    endtask

    initial begin
        clr_in();
        rst = 1'b1;
        // Outputs must stay low under reset even with a jump and hazard presented.
        ex_jump_req = 1'b1; ex_jump_addr = 32'hDEAD_BEEF; bus_hold_req = 1'b1;
        #2;
        chk_a("in_rst", S_IDLE, 32'd0);
        do_reset();

        // Load-use hazard on rs1: one stall cycle, then a silent LU_STALL cycle.
        set_hz(5'd5, 1'b1);
        #2; chk_a("lu_hz", S_STALL, 32'd0); tick();
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0400;
        #2; chk_a("lu_stall", S_IDLE, 32'd0); tick();
        clr_in();
        #2; chk_a("lu_run", S_IDLE, 32'd0); tick();

        // Non-hazards: rd=x0, rs1 unused, not a load.
        set_hz(5'd0, 1'b1);
        #2; chk_a("hz_rd0", S_IDLE, 32'd0); tick();
        set_hz(5'd5, 1'b0);
        #2; chk_a("hz_unused", S_IDLE, 32'd0); tick();
        set_hz(5'd5, 1'b1); ex_is_load = 1'b0;
        #2; chk_a("hz_noload", S_IDLE, 32'd0); tick();

        // Hazard through rs2.
        clr_in();
        ex_is_load = 1'b1; ex_reg_we = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_used = 1'b1;
        #2; chk_a("hz_rs2", S_STALL, 32'd0); tick();
        clr_in();
        #2; chk_a("hz_rs2_lu", S_IDLE, 32'd0); tick();

        // Taken jump; a second jump and a hold during FLUSH are ignored.
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0100;
        #2; chk_a("jmp", S_JUMP, 32'h0000_0100);
        check_eq("jmp_b_strb", {27'd0, s_b}, {27'd0, S_JUMP});
        tick();
        ex_jump_addr = 32'h0000_0200; bus_hold_req = 1'b1;
        #2; chk_a("jmp_flush", S_FLUSH, 32'd0);
        check_eq("jmp_b_flush1", {27'd0, s_b}, {27'd0, S_FLUSH});
        tick();
        clr_in();
        #2; chk_a("jmp_run", S_IDLE, 32'd0);
        check_eq("jmp_b_flush2", {27'd0, s_b}, {27'd0, S_FLUSH});
        tick();
        #2; check_eq("jmp_b_run", {27'd0, s_b}, 32'd0); tick();

        // Jump, hold and hazard together: jump wins.
        ex_jump_req = 1'b1; ex_jump_addr = 32'h1234_5678; bus_hold_req = 1'b1;
        set_hz(5'd5, 1'b1);
        #2; chk_a("prio", S_JUMP, 32'h1234_5678); tick();
        clr_in();
        #2; chk_a("prio_flush", S_FLUSH, 32'd0); tick();
        tick();

        // Three-cycle bus hold from a fresh reset; a jump during HOLD is ignored.
        do_reset();
        bus_hold_req = 1'b1;
        #2; chk_a("hold1", S_STALL, 32'd0); tick();
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0800;
        #2; chk_a("hold2", S_STALL, 32'd0); tick();
        ex_jump_req = 1'b0;
        #2; chk_a("hold3", S_STALL, 32'd0); tick();
        bus_hold_req = 1'b0;
        #2; chk_a("hold_rel", S_IDLE, 32'd0); tick();
        #2; chk_a("hold_run", S_IDLE, 32'd0);
        check_eq("hold_stall_cnt", stall_cnt_a, PERF ? 32'd3 : 32'd0);
        check_eq("hold_flush_cnt", flush_cnt_a, 32'd0);
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0010;
        tick();
        clr_in();
        #2; check_eq("jmp_flush_cnt", flush_cnt_a, PERF ? 32'd1 : 32'd0);
        tick();
        tick();

        // Reset mid-FLUSH (instance b has fcnt=1) aborts the flush at once.
        do_reset();
        ex_jump_req = 1'b1; ex_jump_addr = 32'h0000_0300;
        #2; check_eq("rstfl_jmp_b", {27'd0, s_b}, {27'd0, S_JUMP}); tick();
        clr_in();
        #2; check_eq("rstfl_pre_b", {27'd0, s_b}, {27'd0, S_FLUSH});
        rst = 1'b1;
        #1; check_eq("rstfl_now_b", {27'd0, s_b}, 32'd0);
        check_eq("rstfl_now_a", {27'd0, s_a}, 32'd0);
        tick();
        rst = 1'b0;
        #2; check_eq("rstfl_run_b", {27'd0, s_b}, 32'd0);
        check_eq("rstfl_addr_b", jump_addr_b, 32'd0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
